// File: rtl/simon_pkg.sv
// Shared Simon definitions: colour encoding, player FSM states and timer helpers.
package simon_pkg;

  localparam int COLOR_W = 2;

  typedef enum logic [COLOR_W-1:0] {
    CLR_B = 2'b00,
    CLR_G = 2'b01,
    CLR_R = 2'b10,
    CLR_Y = 2'b11
  } color_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ON,
    ST_OFF,
    ST_DONE
  } player_state_e;

  // Halved phase length used by the speed-up mode, never shorter than one cycle.
  function automatic int half_min1(input int v);
    return ((v >> 1) < 1) ? 1 : (v >> 1);
  endfunction

endpackage

// File: rtl/seq_phase_timer.sv
// Loadable down-counter shared by the ON and OFF lamp phases; holds at zero.
module seq_phase_timer
  import simon_pkg::*;
#(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/color_seq_player.sv
// Plays the stored Simon colour sequence through show_color (color/go).
// Optional SEQ_SPEEDUP_EN halves ON/OFF times once len_q >= SPEEDUP_LEN.
module color_seq_player
  import simon_pkg::*;
#(
  parameter int MAX_LEN     = 32,
  parameter int ADDR_W      = 5,
  parameter int ON_CYCLES   = 25000000,
  parameter int OFF_CYCLES  = 12500000,
  parameter int CNT_W       = 25,
  parameter int SPEEDUP_LEN = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [ADDR_W:0]    length,
  input  logic               abort,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_color,
  output logic [COLOR_W-1:0] color,
  output logic               go,
  output logic               busy,
  output logic               done
);

`ifdef SEQ_SPEEDUP_EN
  localparam bit SPEEDUP_ON = 1'b1;
`else
  localparam bit SPEEDUP_ON = 1'b0;
`endif

  localparam logic [ADDR_W:0]  LEN_MAX  = (ADDR_W+1)'(MAX_LEN);
  localparam logic [ADDR_W:0]  IDX_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W+1:0] FAST_MIN = (ADDR_W+2)'(SPEEDUP_LEN);
  localparam logic [CNT_W-1:0] ON_FULL  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_FULL = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_FAST  = CNT_W'(half_min1(ON_CYCLES) - 1);
  localparam logic [CNT_W-1:0] OFF_FAST = CNT_W'(half_min1(OFF_CYCLES) - 1);

  player_state_e      state_q, state_d;
  logic [COLOR_W-1:0] ram_q [MAX_LEN];
  logic [ADDR_W:0]    idx_q, idx_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               go_q, busy_q, done_q;
  logic               fast;
  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_expired;

  assign fast = SPEEDUP_ON && ({1'b0, len_q} >= FAST_MIN);

  seq_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    color_d  = color_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (length == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
            len_d   = (length > LEN_MAX) ? LEN_MAX : length;
            idx_d   = '0;
          end
        end
      end
      ST_LOAD: begin
        color_d  = ram_q[idx_q[ADDR_W-1:0]];
        tmr_load = 1'b1;
        tmr_val  = fast ? ON_FAST : ON_FULL;
        state_d  = ST_ON;
      end
      ST_ON: begin
        if (tmr_expired) begin
          tmr_load = 1'b1;
          tmr_val  = fast ? OFF_FAST : OFF_FULL;
          state_d  = ST_OFF;
        end
      end
      ST_OFF: begin
        if (tmr_expired) begin
          if (idx_q + IDX_ONE == len_q) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      color_q <= '0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      color_q <= color_d;
      go_q    <= (state_d == ST_ON);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !busy_q) begin
      ram_q[wr_addr] <= wr_color;
    end
  end

  assign color = color_q;
  assign go    = go_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_color_seq_player.sv
// Directed bench for color_seq_player with a lamp scoreboard (ON=4, OFF=2, MAX_LEN=8).
module tb_color_seq_player;
  import simon_pkg::*;

  localparam int ON   = 4;
  localparam int OFF  = 2;
  localparam int MAXL = 8;
  localparam int WAIT_LIMIT = 200;

  typedef struct {
    logic [1:0] c;
    int         on;
    int         off;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn, start, abort, wr_en;
  logic [3:0] length;
  logic [2:0] wr_addr;
  logic [1:0] wr_color;
  logic [1:0] color;
  logic       go, busy, done;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   d0 = 0;
  int   r0 = 0;
  int   rise_cnt = 0;
  int   done_cnt = 0;
  bit   mon_skip = 1'b0;
  exp_t exp_q[$];
  logic [1:0] mem [MAXL];

  color_seq_player #(
    .MAX_LEN     (MAXL),
    .ADDR_W      (3),
    .ON_CYCLES   (ON),
    .OFF_CYCLES  (OFF),
    .CNT_W       (3),
    .SPEEDUP_LEN (2)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .length   (length),
    .abort    (abort),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_color (wr_color),
    .color    (color),
    .go       (go),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int eff_on(input int n);
`ifdef SEQ_SPEEDUP_EN
    return (n >= 2) ? 2 : ON;
`else
    return ON;
`endif
  endfunction

  function automatic int eff_off(input int n);
`ifdef SEQ_SPEEDUP_EN
    return (n >= 2) ? 1 : OFF;
`else
    return OFF;
`endif
  endfunction

  // Lamp monitor: colour checked when go rises, duration when it falls, gap at next rise.
  logic go_prev = 1'b0;
  int   on_cnt = 0, gap_cnt = 0, last_off = 0;
  bit   have_gap = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!resetn) begin
      go_prev  = 1'b0;
      on_cnt   = 0;
      gap_cnt  = 0;
      have_gap = 1'b0;
      exp_q.delete();
    end else begin
      if (go) begin
        if (!go_prev) begin
          rise_cnt++;
          if (have_gap) check("gap_cycles", gap_cnt, last_off + 1);
          if (!mon_skip && exp_q.size() > 0) check("color_at_rise", color, exp_q[0].c);
        end
        on_cnt++;
      end else begin
        if (go_prev) begin
          if (mon_skip) begin
            have_gap = 1'b0;
          end else if (exp_q.size() == 0) begin
            check("unexpected_lamp", 1, 0);
          end else begin
            mon_e = exp_q.pop_front();
            check("color_at_fall", color, mon_e.c);
            check("on_cycles", on_cnt, mon_e.on);
            last_off = mon_e.off;
            have_gap = 1'b1;
          end
          on_cnt  = 0;
          gap_cnt = 0;
        end
        if (have_gap) gap_cnt++;
      end
      if (done) begin
        done_cnt++;
        have_gap = 1'b0;
      end
      go_prev = go;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int a, input logic [1:0] c);
    wr_en = 1'b1; wr_addr = 3'(a); wr_color = c;
    mem[a] = c;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_play(input int len);
    int n;
    n = (len > MAXL) ? MAXL : len;
    for (int i = 0; i < n; i++) exp_q.push_back('{mem[i], eff_on(n), eff_off(n)});
    d0 = done_cnt;
    start = 1'b1; length = 4'(len);
    tick();
    start = 1'b0; wr_en = 1'b0;
    start_cyc = cyc;
    if (n == 0) begin
      check("len0_done", done, 1);
      check("len0_go", go, 0);
    end else begin
      check("busy_after_start", busy, 1);
      check("go_after_start", go, 0);
      tick();
      check("go_second_cycle", go, 1);
    end
  endtask

  task automatic wait_done(input int len);
    int n, k;
    n = (len > MAXL) ? MAXL : len;
    k = 0;
    while (done !== 1'b1 && k < WAIT_LIMIT) begin
      tick();
      k++;
    end
    // Offsets counted from the edge that accepted start.
    check("done_latency", cyc - start_cyc, n * (1 + eff_on(n) + eff_off(n)));
    tick();
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("done_pulses", done_cnt - d0, 1);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic play(input int len);
    start_play(len);
    wait_done(len);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0; wr_en = 1'b0;
    length = '0; wr_addr = '0; wr_color = '0;
    repeat (3) tick();
    check("rst_color", color, 0);
    check("rst_go", go, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    resetn = 1'b1;
    tick();

    write(0, CLR_R); write(1, CLR_G); write(2, CLR_Y); write(3, CLR_B);
    write(4, CLR_G); write(5, CLR_Y); write(6, CLR_R); write(7, CLR_B);

    play(3);
    play(0);
    play(9);

    // Abort during the second colour's ON phase, then replay from entry 0.
    r0 = rise_cnt;
    start_play(3);
    for (int k = 0; k < WAIT_LIMIT && rise_cnt < r0 + 2; k++) tick();
    check("abort_reach_second", rise_cnt - r0, 2);
    mon_skip = 1'b1;
    exp_q.delete();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_go", go, 0);
    check("abort_busy", busy, 0);
    d0 = done_cnt;
    repeat (12) tick();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle_busy", busy, 0);
    mon_skip = 1'b0;
    play(3);

    // Write while busy is dropped; old colours remain.
    start_play(3);
    wr_en = 1'b1; wr_addr = 3'd1; wr_color = CLR_B;
    tick();
    wr_en = 1'b0;
    wait_done(3);
    play(3);

    // Write and start in the same cycle: new colour shown first.
    mem[0] = CLR_Y;
    wr_en = 1'b1; wr_addr = 3'd0; wr_color = CLR_Y;
    start_play(1);
    wait_done(1);

    // Asynchronous reset in the middle of an ON phase.
    r0 = rise_cnt;
    start_play(3);
    tick();
    resetn = 1'b0;
    #1;
    check("midrst_go", go, 0);
    check("midrst_busy", busy, 0);
    check("midrst_color", color, 0);
    check("midrst_done", done, 0);
    repeat (2) tick();
    resetn = 1'b1;
    repeat (6) tick();
    check("postrst_busy", busy, 0);
    check("postrst_go", go, 0);
    check("postrst_lamps", rise_cnt - r0, 1);

    // Length 2 reaches SPEEDUP_LEN=2; timing depends on the build option.
    play(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
